// File: rtl/rf_pkg.sv
// rf_pkg: register-file write-port constants shared by the writeback arbiter.
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_out_reg.sv
// wb_out_reg: registered register-file write port; writes to x0 are dropped
// and leave the address/data flops untouched.
module wb_out_reg
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]       data,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]       wdata
);
    logic live;

    assign live = en && addr != ZERO_REG;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            we <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= live;
            if (live) begin
                waddr <= addr;
                wdata <= data;
            end
        end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-requester writeback arbiter (LSU over ALU) with an
// ALU anti-starvation override and same-rd ordering protection.
module wb_port_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  alu_starve
);
    localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

    logic [2:0] loss;
    logic collide, alu_pri;

    assign alu_starve = loss >= LIM;
    // a same-rd pair keeps the older load first even under starvation
    assign collide = alu_valid && lsu_valid && alu_rd == lsu_rd && alu_rd != ZERO_REG;
    assign alu_pri = alu_starve && !collide;
    assign alu_ready = rst_n && alu_valid && (!lsu_valid || alu_pri);
    assign lsu_ready = rst_n && lsu_valid && (!alu_valid || !alu_pri);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            loss <= 3'd0;
        else
            loss <= (!alu_valid || alu_ready) ? 3'd0 : (&loss ? loss : loss + 3'd1);

    wb_out_reg u_out (
        .clk(clk),
        .rst_n(rst_n),
        .en(alu_ready || lsu_ready),
        .addr(lsu_ready ? lsu_rd : alu_rd),
        .data(lsu_ready ? lsu_data : alu_data),
        .we(rf_we),
        .waddr(rf_waddr),
        .wdata(rf_wdata)
    );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the arbitration rules.
module tb_wb_port_arbiter;
    localparam int LIM = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0] alu_rd = '0, lsu_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic alu_ready, lsu_ready, rf_we, alu_starve;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0, failures = 0;
    int m_loss = 0;
    logic e_we = 1'b0;
    logic [4:0] e_waddr = '0;
    logic [31:0] e_wdata = '0;
    logic ga, gl;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_starve(alu_starve)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one cycle: drive, check grants against the model, then check the write
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        output logic oa, output logic ol);
        logic starve, lsu_first, xa, xl;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
        @(negedge clk);
        starve = m_loss >= LIM;
        lsu_first = !starve || (av && lv && ar == lr && ar != 0);
        xa = av && (!lv || !lsu_first);
        xl = lv && !xa;
        chk("alu_ready", alu_ready, xa);
        chk("lsu_ready", lsu_ready, xl);
        chk("alu_starve", alu_starve, starve);
        oa = alu_ready;
        ol = lsu_ready;
        m_loss = (av && !xa) ? (m_loss < 7 ? m_loss + 1 : 7) : 0;
        e_we = 1'b0;
        if (xa && ar != 0) begin e_we = 1'b1; e_waddr = ar; e_wdata = ad; end
        if (xl && lr != 0) begin e_we = 1'b1; e_waddr = lr; e_wdata = ld; end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, e_we);
        chk("rf_waddr", rf_waddr, e_waddr);
        chk("rf_wdata", rf_wdata, e_wdata);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, rf_we, 0);
        chk({tag, "_waddr"}, rf_waddr, 0);
        chk({tag, "_wdata"}, rf_wdata, 0);
        chk({tag, "_starve"}, alu_starve, 0);
        chk({tag, "_alu_rdy"}, alu_ready, 0);
        chk({tag, "_lsu_rdy"}, lsu_ready, 0);
    endtask

    initial begin
        logic pa, pl;
        logic [4:0] par, plr;
        logic [31:0] pad, pld;
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd4; lsu_rd = 5'd6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(0, 0, 0, 1, 5'd3, 32'hDEADBEEF, ga, gl);
        chk("single_lsu_rdy", gl, 1);
        chk("single_we", rf_we, 1);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, ga, gl);
        chk("idle_we", rf_we, 0);

        for (int i = 0; i < 6; i++) begin
            step(1, 5'd1, 32'hA000_0000 + i, 1, 5'd2, 32'hB000_0000 + i, ga, gl);
            chk("cont_alu", ga, i % 3 == 2);
            chk("cont_waddr", rf_waddr, (i % 3 == 2) ? 1 : 2);
        end
        step(0, 0, 0, 0, 0, 0, ga, gl);

        step(1, 5'd7, 32'hAAAA_0007, 1, 5'd2, 32'h1, ga, gl);
        step(1, 5'd7, 32'hAAAA_0007, 1, 5'd2, 32'h2, ga, gl);
        chk("coll_loss2_starve", alu_starve, 1);
        step(1, 5'd7, 32'hAAAA_0007, 1, 5'd7, 32'h5555_0007, ga, gl);
        chk("coll_lsu_first", gl, 1);
        chk("coll_wdata1", rf_wdata, 32'h5555_0007);
        step(1, 5'd7, 32'hAAAA_0007, 0, 0, 0, ga, gl);
        chk("coll_alu_second", ga, 1);
        chk("coll_wdata2", rf_wdata, 32'hAAAA_0007);

        step(1, 5'd0, 32'h12345678, 0, 0, 0, ga, gl);
        chk("x0_alu_rdy", ga, 1);
        chk("x0_we", rf_we, 0);
        chk("x0_hold", rf_wdata, 32'hAAAA_0007);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 5'(8 + i), 32'hC0 + i, 0, 0, 0, ga, gl);
            else step(0, 0, 0, 1, 5'(8 + i), 32'hC0 + i, ga, gl);
            chk("thru_we", rf_we, 1);
            chk("thru_waddr", rf_waddr, 8 + i);
        end

        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5;
        lsu_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk);
        #1;
        chk("midrst_we", rf_we, 0);
        alu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_we", rf_we, 0);
        m_loss = 0; e_we = 0; e_waddr = 0; e_wdata = 0;

        pa = 0; pl = 0; par = 0; plr = 0; pad = 0; pld = 0;
        for (int i = 0; i < 500; i++) begin
            if (!pa && $urandom_range(0, 9) < 6) begin
                pa = 1; par = 5'($urandom_range(0, 3)); pad = $urandom;
            end
            if (!pl && $urandom_range(0, 9) < 6) begin
                pl = 1; plr = 5'($urandom_range(0, 3)); pld = $urandom;
            end
            step(pa, par, pad, pl, plr, pld, ga, gl);
            if (ga) pa = 0;
            if (gl) pl = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
